// File: rtl/edge_write_controller.sv
// edge_write_controller: final Canny stage. Buffers processed pixels in a small FIFO and
// writes them in raster order to the write SRAM with a two-phase (setup, strobe) cycle.
// Optional feature: define BORDER_ZERO_EN to force border pixels to 0 on write.
module edge_write_controller #(
  parameter int unsigned IMG_W      = 512,
  parameter int unsigned IMG_H      = 512,
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              write_enable_w,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned NumPix = IMG_W * IMG_H;
  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = ADDR_W + 1;
  localparam logic [CntW-1:0]   NumPixC  = CntW'(NumPix);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NumPix - 1);
  localparam logic [PtrW:0]     FullCnt  = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   acc_cnt_q, acc_cnt_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]     count_q, count_d;
  logic              armed_q, armed_d;   // address/data loaded, strobe due next cycle
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic fifo_full, fifo_empty, push, pop;
  logic active, frame_start, final_strobe, adv, pix_zero;

  assign fifo_full    = (count_q == FullCnt);
  assign fifo_empty   = (count_q == '0);
  assign active       = (state_q == StRun) || (state_q == StDrain);
  assign frame_start  = (state_q == StIdle) && start;
  // Strobe visible this cycle for the last pixel of the frame.
  assign final_strobe = we_q && (wr_cnt_q == LastAddr);
  // A non-final strobe completes at this edge: advance the write position.
  assign adv          = active && !armed_q && we_q && !final_strobe;

  // No pop look-ahead: readiness comes from registered state only.
  assign in_ready = (state_q == StRun) && !fifo_full && (acc_cnt_q < NumPixC);
  assign push     = in_valid && in_ready;

`ifdef BORDER_ZERO_EN
  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;

  // Row/column of the address the next pop will use, tracking wr_cnt.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (frame_start) begin
      col_d = '0;
      row_d = '0;
    end else if (adv) begin
      if (col_q == ColW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  // Row/column registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign pix_zero = (row_d == '0) || (row_d == RowW'(IMG_H - 1)) ||
                    (col_d == '0) || (col_d == ColW'(IMG_W - 1));
`else
  assign pix_zero = 1'b0;
`endif

  // FIFO storage; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= in_data;
    end
  end

  // Next-state for frame control, FIFO pointers and the two-phase write engine.
  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    armed_d   = armed_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    error_d   = error_q;
    pop       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          acc_cnt_d = '0;
          wr_cnt_d  = '0;
          armed_d   = 1'b0;
          error_d   = 1'b0;
        end
        if (in_valid) begin
          error_d = 1'b1;
        end
      end
      StRun, StDrain: begin
        if (start) begin
          error_d = 1'b1;
        end
        if (push) begin
          acc_cnt_d = acc_cnt_q + CntW'(1);
        end
        if ((state_q == StRun) && (acc_cnt_d == NumPixC)) begin
          state_d = StDrain;
        end
        if (armed_q) begin
          we_d    = 1'b1;
          armed_d = 1'b0;
        end else begin
          if (adv) begin
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
          end
          if (final_strobe) begin
            if ((state_q == StDrain) && fifo_empty) begin
              state_d = StDone;
            end
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            armed_d = 1'b1;
            addr_d  = wr_cnt_d;
            data_d  = pix_zero ? '0 : fifo_mem[rd_ptr_q];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (in_valid) begin
          error_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    count_d  = count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
    if (frame_start) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end

    busy_d = (state_d == StRun) || (state_d == StDrain);
    done_d = (state_d == StDone);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      armed_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      armed_q   <= armed_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign write_enable_w = we_q;
  assign write_address  = addr_q;
  assign write_data     = data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule
